// File: rtl/dm_cache.sv
// Direct-mapped, write-back, write-allocate cache between a word-wide CPU port and a block-wide memory.
// Optional hit/miss statistics outputs are enabled with the DM_CACHE_STATS_EN macro.
module dm_cache #(
    parameter int c_block_size = 2,
    parameter int c_line_size  = 32,
    parameter int address_size = 32,
    parameter int c_index_size = 3
) (
    input  logic                                      c_clk_i,
    input  logic                                      c_reset_i,
    input  logic                                      cpu_read_i,
    input  logic                                      cpu_write_i,
    input  logic [address_size-1:0]                   cpu_addr_i,
    input  logic [c_line_size-1:0]                    cpu_wr_data_i,
    output logic [c_line_size-1:0]                    cpu_rd_data_o,
    output logic                                      cpu_busywait_o,
    output logic                                      mem_read_o,
    output logic                                      mem_write_o,
    output logic [address_size-c_block_size-3:0]      mem_addr_o,
    output logic [(2**c_block_size)*c_line_size-1:0]  mem_wr_data_o,
    input  logic [(2**c_block_size)*c_line_size-1:0]  mem_rd_data_i,
    input  logic                                      mem_busywait_i,
    input  logic                                      mem_read_done_i,
    input  logic                                      mem_write_done_i
`ifdef DM_CACHE_STATS_EN
    ,
    output logic [31:0]                               hit_count_o,
    output logic [31:0]                               miss_count_o
`endif
);

    localparam int blk_w  = (2**c_block_size) * c_line_size;
    localparam int lines  = 2**c_index_size;
    localparam int tag_w  = address_size - c_index_size - c_block_size - 2;
    localparam int maddr_w = address_size - c_block_size - 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2,
        UPDATE    = 2'd3
    } state_t;

    state_t                  state_r;
    logic [blk_w-1:0]        data_arr [lines];
    logic [tag_w-1:0]        tag_arr  [lines];
    logic [lines-1:0]        valid_r;
    logic [lines-1:0]        dirty_r;
    logic [blk_w-1:0]        fill_r;
    logic                    mem_read_r;
    logic                    mem_write_r;
    logic [maddr_w-1:0]      mem_addr_r;
    logic [blk_w-1:0]        mem_wr_data_r;

    logic [c_block_size-1:0] offset_s;
    logic [c_index_size-1:0] index_s;
    logic [tag_w-1:0]        tag_s;
    logic                    req_s;
    logic                    hit_s;
    logic                    idle_s;
    logic                    wr_hit_s;
    logic                    rd_hit_s;
    logic                    unused_s;

    assign offset_s = cpu_addr_i[c_block_size+1:2];
    assign index_s  = cpu_addr_i[c_block_size+2 +: c_index_size];
    assign tag_s    = cpu_addr_i[address_size-1 -: tag_w];
    assign unused_s = ^{cpu_addr_i[1:0], mem_busywait_i};

    assign req_s    = cpu_read_i | cpu_write_i;
    assign idle_s   = (state_r == IDLE);
    assign hit_s    = valid_r[index_s] && (tag_arr[index_s] == tag_s);
    // A simultaneous read and write is treated as a plain read.
    assign rd_hit_s = idle_s && cpu_read_i && hit_s && !c_reset_i;
    assign wr_hit_s = idle_s && cpu_write_i && !cpu_read_i && hit_s;

    assign cpu_busywait_o = !c_reset_i && (!idle_s || (req_s && !hit_s));
    assign cpu_rd_data_o  = rd_hit_s ? data_arr[index_s][offset_s*c_line_size +: c_line_size]
                                     : {c_line_size{1'b0}};
    assign mem_read_o     = mem_read_r;
    assign mem_write_o    = mem_write_r;
    assign mem_addr_o     = mem_addr_r;
    assign mem_wr_data_o  = mem_wr_data_r;

    // Data and tag storage; contents only matter once the line's valid bit is set.
    always_ff @(posedge c_clk_i) begin
        if (!c_reset_i) begin
            if (state_r == UPDATE) begin
                data_arr[index_s] <= fill_r;
                tag_arr[index_s]  <= tag_s;
            end else if (wr_hit_s) begin
                data_arr[index_s][offset_s*c_line_size +: c_line_size] <= cpu_wr_data_i;
            end
        end
    end

    // Miss-handling FSM with registered memory-side outputs and line status bits.
    always_ff @(posedge c_clk_i) begin
        if (c_reset_i) begin
            state_r       <= IDLE;
            valid_r       <= {lines{1'b0}};
            dirty_r       <= {lines{1'b0}};
            fill_r        <= {blk_w{1'b0}};
            mem_read_r    <= 1'b0;
            mem_write_r   <= 1'b0;
            mem_addr_r    <= {maddr_w{1'b0}};
            mem_wr_data_r <= {blk_w{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_s && !hit_s) begin
                        if (valid_r[index_s] && dirty_r[index_s]) begin
                            mem_write_r   <= 1'b1;
                            mem_addr_r    <= {tag_arr[index_s], index_s};
                            mem_wr_data_r <= data_arr[index_s];
                            state_r       <= WRITEBACK;
                        end else begin
                            mem_read_r <= 1'b1;
                            mem_addr_r <= {tag_s, index_s};
                            state_r    <= ALLOCATE;
                        end
                    end else if (wr_hit_s) begin
                        dirty_r[index_s] <= 1'b1;
                    end
                end
                WRITEBACK: begin
                    if (mem_write_done_i) begin
                        mem_write_r <= 1'b0;
                        mem_read_r  <= 1'b1;
                        mem_addr_r  <= {tag_s, index_s};
                        state_r     <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    if (mem_read_done_i) begin
                        mem_read_r <= 1'b0;
                        fill_r     <= mem_rd_data_i;
                        state_r    <= UPDATE;
                    end
                end
                UPDATE: begin
                    valid_r[index_s] <= 1'b1;
                    dirty_r[index_s] <= 1'b0;
                    state_r          <= IDLE;
                end
                default: begin
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

`ifdef DM_CACHE_STATS_EN
    logic [31:0] hit_cnt_r;
    logic [31:0] miss_cnt_r;
    logic        replay_r;

    assign hit_count_o  = hit_cnt_r;
    assign miss_count_o = miss_cnt_r;

    // The hit seen right after a refill completes an already-counted miss, so it is not counted again.
    always_ff @(posedge c_clk_i) begin
        if (c_reset_i) begin
            hit_cnt_r  <= 32'd0;
            miss_cnt_r <= 32'd0;
            replay_r   <= 1'b0;
        end else begin
            replay_r <= (state_r == UPDATE);
            if (idle_s && req_s && hit_s && !replay_r) begin
                hit_cnt_r <= hit_cnt_r + 32'd1;
            end else if (idle_s && req_s && !hit_s) begin
                miss_cnt_r <= miss_cnt_r + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dm_cache.sv
// Scoreboard bench for dm_cache: stimulus pushes expected events, a negedge monitor pops and compares.
module tb_dm_cache;

    localparam int K_RD = 0;
    localparam int K_WR = 1;
    localparam int K_WB = 2;
    localparam int K_AL = 3;

    typedef struct {
        int           kind;
        logic [27:0]  addr;
        logic [127:0] data;
        string        name;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cpu_read = 1'b0;
    logic         cpu_write = 1'b0;
    logic [31:0]  cpu_addr = 32'd0;
    logic [31:0]  cpu_wdata = 32'd0;
    logic [31:0]  cpu_rdata;
    logic         cpu_busy;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata = 128'd0;
    logic         mem_busy = 1'b0;
    logic         mem_rdone = 1'b0;
    logic         mem_wdone = 1'b0;
`ifdef DM_CACHE_STATS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    int           errors = 0;
    int           checks = 0;
    int           resp_cnt = 0;
    logic         prev_rd = 1'b0;
    logic         prev_wr = 1'b0;
    exp_t         sb[$];
    logic [127:0] bench_mem [logic [27:0]];

    dm_cache dut (
        .c_clk_i          (clk),
        .c_reset_i        (rst),
        .cpu_read_i       (cpu_read),
        .cpu_write_i      (cpu_write),
        .cpu_addr_i       (cpu_addr),
        .cpu_wr_data_i    (cpu_wdata),
        .cpu_rd_data_o    (cpu_rdata),
        .cpu_busywait_o   (cpu_busy),
        .mem_read_o       (mem_read),
        .mem_write_o      (mem_write),
        .mem_addr_o       (mem_addr),
        .mem_wr_data_o    (mem_wdata),
        .mem_rd_data_i    (mem_rdata),
        .mem_busywait_i   (mem_busy),
        .mem_read_done_i  (mem_rdone),
        .mem_write_done_i (mem_wdone)
`ifdef DM_CACHE_STATS_EN
        ,
        .hit_count_o      (hit_count),
        .miss_count_o     (miss_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Memory contents: word at byte address a holds a ^ 0x5A5A0000 unless written back.
    function automatic logic [31:0] mw(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [127:0] mblk(input logic [27:0] b);
        logic [127:0] r;
        logic [31:0]  base;
        if (bench_mem.exists(b)) return bench_mem[b];
        base = {b, 4'h0};
        for (int w = 0; w < 4; w++) r[w*32 +: 32] = mw(base + 32'(w * 4));
        return r;
    endfunction

    // Memory responder: done pulse on the third negedge a request is seen; abandoned on reset.
    always @(negedge clk) begin
        mem_rdone = 1'b0;
        mem_wdone = 1'b0;
        if (rst) begin
            resp_cnt = 0;
        end else if (mem_write || mem_read) begin
            if (resp_cnt == 2) begin
                resp_cnt = 0;
                if (mem_write) begin
                    bench_mem[mem_addr] = mem_wdata;
                    mem_wdone = 1'b1;
                end else begin
                    mem_rdata = mblk(mem_addr);
                    mem_rdone = 1'b1;
                end
            end else begin
                resp_cnt++;
            end
        end else begin
            resp_cnt = 0;
        end
    end

    task automatic push(input int kind, input logic [27:0] addr, input logic [127:0] data,
                        input string name);
        exp_t e;
        e.kind = kind; e.addr = addr; e.data = data; e.name = name;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input int kind, input logic [27:0] addr, input logic [127:0] data);
        exp_t e;
        logic ok;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: kind=%0d addr=%h data=%h, required no event", kind, addr, data);
        end else begin
            e = sb.pop_front();
            ok = (e.kind == kind);
            if (ok && kind == K_WB) ok = (addr == e.addr) && (data == e.data);
            if (ok && kind == K_AL) ok = (addr == e.addr);
            if (ok && kind == K_RD) ok = (data[31:0] == e.data[31:0]);
            if (!ok) begin
                errors++;
                $display("FAIL %s: got kind=%0d addr=%h data=%h, required kind=%0d addr=%h data=%h",
                         e.name, kind, addr, data, e.kind, e.addr, e.data);
            end
        end
    endtask

    // Monitor: memory request starts and CPU completions are matched against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            prev_rd <= 1'b0;
            prev_wr <= 1'b0;
        end else begin
            if (mem_write && !prev_wr) pop_cmp(K_WB, mem_addr, mem_wdata);
            if (mem_read && !prev_rd) pop_cmp(K_AL, mem_addr, 128'd0);
            if ((cpu_read || cpu_write) && !cpu_busy)
                pop_cmp(cpu_read ? K_RD : K_WR, 28'd0, {96'd0, cpu_rdata});
            prev_rd <= mem_read;
            prev_wr <= mem_write;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic cpu_op(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat);
        @(posedge clk); #1;
        cpu_read = rd; cpu_write = wr; cpu_addr = addr; cpu_wdata = wdata;
        lat = 0;
        forever begin
            @(negedge clk);
            if (!cpu_busy) break;
            lat++;
            if (lat > 200) begin
                checks++; errors++;
                $display("FAIL busywait_timeout: addr=%h still busy, required release", addr);
                break;
            end
        end
        @(posedge clk); #1;
        cpu_read = 1'b0; cpu_write = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
    endtask

    initial begin
        int  lat;
        bit  seen;
        do_reset();
        @(negedge clk);
        chk("rst_busywait", int'(cpu_busy), 0);
        chk("rst_mem_read", int'(mem_read), 0);
        chk("rst_mem_write", int'(mem_write), 0);
        chk("rst_rd_data", int'(cpu_rdata), 0);

        // Cold read miss: allocate block 1 only.
        push(K_AL, 28'h1, 128'd0, "alloc_0x10");
        push(K_RD, 28'd0, {96'd0, mw(32'h10)}, "rd_0x10_miss");
        cpu_op(1'b1, 1'b0, 32'h10, 32'd0, lat);  chk("lat_miss_0x10", lat, 5);

        push(K_RD, 28'd0, {96'd0, mw(32'h14)}, "rd_0x14_hit");
        cpu_op(1'b1, 1'b0, 32'h14, 32'd0, lat);  chk("lat_hit_0x14", lat, 0);

        push(K_WR, 28'd0, 128'd0, "wr_0x10_hit");
        cpu_op(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, lat);  chk("lat_wr_hit", lat, 0);
        push(K_RD, 28'd0, {96'd0, 32'hDEAD_BEEF}, "rd_0x10_after_wr");
        cpu_op(1'b1, 1'b0, 32'h10, 32'd0, lat);  chk("lat_rd_after_wr", lat, 0);

        // Conflict on a dirty line: write back block 1, then fetch block 0x21.
        push(K_WB, 28'h1, {mw(32'h1C), mw(32'h18), mw(32'h14), 32'hDEAD_BEEF}, "wb_blk1");
        push(K_AL, 28'h21, 128'd0, "alloc_0x210");
        push(K_RD, 28'd0, {96'd0, mw(32'h210)}, "rd_0x210");
        cpu_op(1'b1, 1'b0, 32'h210, 32'd0, lat);  chk("lat_wb_miss", lat, 8);

        push(K_AL, 28'h1, 128'd0, "alloc_0x10_clean");
        push(K_RD, 28'd0, {96'd0, 32'hDEAD_BEEF}, "rd_0x10_from_mem");
        cpu_op(1'b1, 1'b0, 32'h10, 32'd0, lat);  chk("lat_clean_miss", lat, 5);

        // Read and write together: read wins, line stays clean and unmodified.
        push(K_RD, 28'd0, {96'd0, 32'hDEAD_BEEF}, "rd_wr_both");
        cpu_op(1'b1, 1'b1, 32'h10, 32'h1234_5678, lat);  chk("lat_rd_wr_both", lat, 0);
        push(K_AL, 28'h21, 128'd0, "alloc_0x210_nowb");
        push(K_RD, 28'd0, {96'd0, mw(32'h210)}, "rd_0x210_again");
        cpu_op(1'b1, 1'b0, 32'h210, 32'd0, lat);  chk("lat_no_wb", lat, 5);
        push(K_AL, 28'h1, 128'd0, "alloc_0x10_again");
        push(K_RD, 28'd0, {96'd0, 32'hDEAD_BEEF}, "rd_0x10_unmodified");
        cpu_op(1'b1, 1'b0, 32'h10, 32'd0, lat);  chk("lat_refetch", lat, 5);

        // Write-allocate on another index.
        push(K_AL, 28'h2, 128'd0, "alloc_0x24");
        push(K_WR, 28'd0, 128'd0, "wr_miss_0x24");
        cpu_op(1'b0, 1'b1, 32'h24, 32'hCAFE_F00D, lat);  chk("lat_wr_miss", lat, 5);
        push(K_RD, 28'd0, {96'd0, 32'hCAFE_F00D}, "rd_0x24");
        cpu_op(1'b1, 1'b0, 32'h24, 32'd0, lat);  chk("lat_rd_0x24", lat, 0);
        push(K_RD, 28'd0, {96'd0, mw(32'h20)}, "rd_0x20");
        cpu_op(1'b1, 1'b0, 32'h20, 32'd0, lat);  chk("lat_rd_0x20", lat, 0);

        // Reset in the middle of an allocate abandons it.
        push(K_AL, 28'h41, 128'd0, "alloc_0x410");
        @(posedge clk); #1;
        cpu_read = 1'b1; cpu_addr = 32'h410;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = mem_read;
        end
        chk("alloc_started", int'(seen), 1);
        @(posedge clk); #1;
        rst = 1'b1; cpu_read = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_mem_read", int'(mem_read), 0);
        chk("rst_mid_busywait", int'(cpu_busy), 0);
        push(K_AL, 28'h1, 128'd0, "alloc_0x10_after_rst");
        push(K_RD, 28'd0, {96'd0, 32'hDEAD_BEEF}, "rd_0x10_after_rst");
        cpu_op(1'b1, 1'b0, 32'h10, 32'd0, lat);  chk("lat_after_rst", lat, 5);

`ifdef DM_CACHE_STATS_EN
        do_reset();
        push(K_AL, 28'h4, 128'd0, "alloc_0x44");
        push(K_RD, 28'd0, {96'd0, mw(32'h44)}, "rd_0x44_miss");
        cpu_op(1'b1, 1'b0, 32'h44, 32'd0, lat);
        push(K_RD, 28'd0, {96'd0, mw(32'h44)}, "rd_0x44_hit");
        cpu_op(1'b1, 1'b0, 32'h44, 32'd0, lat);
        push(K_RD, 28'd0, {96'd0, mw(32'h48)}, "rd_0x48_hit");
        cpu_op(1'b1, 1'b0, 32'h48, 32'd0, lat);
        @(negedge clk);
        chk("hit_count", int'(hit_count), 2);
        chk("miss_count", int'(miss_count), 1);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dm_cache.md
DM_CACHE -- requirements
Module: dm_cache

Interface
REQ-001 Parameters SHALL be:
  c_block_size, 2, log2 of words per block
  c_line_size, 32, word width in bits
  address_size, 32, CPU byte-address width
  c_index_size, 3, log2 of cache lines
REQ-002 Ports SHALL be:
  c_clk_i  in  1  sole clock, all state updates on rising edge
  c_reset_i  in  1  synchronous active-high reset
  cpu_read_i  in  1  word read request, held until busywait low
  cpu_write_i  in  1  word write request, held until busywait low
  cpu_addr_i  in  address_size  byte address; bits [1:0] ignored
  cpu_wr_data_i  in  c_line_size  write word
  cpu_rd_data_o  out  c_line_size  read word, valid while busywait low on read
  cpu_busywait_o  out  1  stall CPU
  mem_read_o  out  1  block fetch request
  mem_write_o  out  1  block write-back request
  mem_addr_o  out  address_size-c_block_size-2  block address
  mem_wr_data_o  out  2**c_block_size*c_line_size  write-back block, word 0 in LSBs
  mem_rd_data_i  in  2**c_block_size*c_line_size  fetched block, word 0 in LSBs
  mem_busywait_i  in  1  memory busy
  mem_read_done_i  in  1  one-cycle pulse, mem_rd_data_i valid
  mem_write_done_i  in  1  one-cycle pulse, block written
REQ-003 One clock; reset is synchronous and active-high.

Function
REQ-004 Direct-mapped, write-back, write-allocate; per line: valid, dirty, tag, 2**c_block_size words.
REQ-005 Address split: offset = addr[c_block_size+1:2], index = next c_index_size bits, tag = remaining upper bits.
REQ-006 States SHALL be IDLE, WRITEBACK, ALLOCATE, UPDATE; outputs are Moore except hit/busywait in IDLE.
REQ-007 IDLE, hit (valid and tag match): read returns word combinationally, busywait 0; write updates word and sets dirty at next edge, busywait 0.
REQ-008 IDLE, miss with request: busywait 1 in same cycle; next state WRITEBACK if line valid and dirty, else ALLOCATE.
REQ-009 WRITEBACK: mem_write_o 1, mem_addr_o = {stored tag, index}, mem_wr_data_o = stored block; on mem_write_done_i go ALLOCATE.
REQ-010 ALLOCATE: mem_read_o 1, mem_addr_o = {request tag, index}; on mem_read_done_i capture mem_rd_data_i and go UPDATE.
REQ-011 UPDATE: write captured block, set tag and valid, clear dirty; busywait 1; next state IDLE, where the request re-evaluates as a hit.
REQ-012 mem_read_o/mem_write_o SHALL drop in the cycle after the done pulse, so the memory never sees a back-to-back request.
REQ-013 Simultaneous cpu_read_i and cpu_write_i: read wins, write ignored.
REQ-014 No request in IDLE: busywait 0, no memory request, array unchanged.
REQ-015 Request address or data changing while busywait 1 is illegal; behaviour unspecified.

Reset
REQ-016 Reset: state IDLE, all valid and dirty cleared, mem_read_o 0, mem_write_o 0, cpu_busywait_o 0, cpu_rd_data_o 0.
REQ-017 Reset mid-WRITEBACK/ALLOCATE abandons the transaction; memory SHALL be reset in the same cycle by the integrator.

Configuration
REQ-018 Macro DM_CACHE_STATS_EN defined: add outputs hit_count_o, miss_count_o (32 bits, wrapping, reset 0), each incremented once per request resolved in IDLE (hit) or per miss entering WRITEBACK/ALLOCATE. Undefined: ports absent, no counter logic.

Verification
REQ-019 After reset, read 0x0000_0010 -> ALLOCATE, mem_addr_o 0x0000001, no WRITEBACK, data = memory word 0x4, busywait low one cycle after UPDATE.
REQ-020 Repeat read 0x0000_0014 -> hit, busywait 0 same cycle, zero memory requests.
REQ-021 Write 0xDEAD_BEEF to 0x10, then read 0x210 (same index, new tag) -> WRITEBACK to block 0x01 with word 0 = 0xDEADBEEF, then ALLOCATE 0x21.
REQ-022 Assert reset during ALLOCATE -> next cycle mem_read_o 0, read of 0x10 misses again.
REQ-023 cpu_read_i and cpu_write_i both high on hit -> read data returned, line dirty bit unchanged.
REQ-024 With DM_CACHE_STATS_EN: sequence miss, hit, hit -> hit_count_o 2, miss_count_o 1.
